// File: rtl/zbuf_pkg.sv
// Shared types and helpers for the z-buffer depth-test stage.
// Fragments are packed MSB to LSB as {x, y, z, color}.
package zbuf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        REQ,
        WAIT_ACK,
        TEST
    } state_t;

    localparam int MAX_FRAG_W = 64;
    typedef logic [MAX_FRAG_W-1:0] frag_bus_t;

    // Far-plane depth; slice down to the depth width in use.
    localparam frag_bus_t Z_FAR = '1;

    function automatic int frag_width(int xb, int yb, int zb, int cb);
        return xb + yb + zb + cb;
    endfunction

    function automatic int addr_width(int xb, int yb);
        return xb + yb;
    endfunction

    function automatic frag_bus_t low_mask(int n);
        return (frag_bus_t'(1) << n) - frag_bus_t'(1);
    endfunction

    function automatic frag_bus_t frag_x(frag_bus_t f, int xb, int yb, int zb, int cb);
        return (f >> (yb + zb + cb)) & low_mask(xb);
    endfunction

    function automatic frag_bus_t frag_y(frag_bus_t f, int yb, int zb, int cb);
        return (f >> (zb + cb)) & low_mask(yb);
    endfunction

    function automatic frag_bus_t frag_z(frag_bus_t f, int zb, int cb);
        return (f >> cb) & low_mask(zb);
    endfunction

    function automatic frag_bus_t frag_color(frag_bus_t f, int cb);
        return f & low_mask(cb);
    endfunction

endpackage

// File: rtl/zbuffer_test_stage_depth_ram.sv
// Depth storage: one synchronous write port, one asynchronous read port, no reset.
module depth_ram #(
    parameter int A_BITS = 8,
    parameter int Z_BITS = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [A_BITS-1:0] waddr,
    input  logic [Z_BITS-1:0] wdata,
    input  logic [A_BITS-1:0] raddr,
    output logic [Z_BITS-1:0] rdata
);

    logic [Z_BITS-1:0] mem [2**A_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/zbuffer_test_stage.sv
// Depth-test stage: pops fragments from the pixel fifo, tests them against
// the depth memory, writes passing fragments to the framebuffer, owns clears.
module zbuffer_test_stage
    import zbuf_pkg::*;
#(
    parameter int X_BITS     = 4,
    parameter int Y_BITS     = 4,
    parameter int Z_BITS     = 8,
    parameter int COLOR_BITS = 8,
    parameter int FILL_BITS  = 8,
    parameter logic [COLOR_BITS-1:0] BG_COLOR = '0,
    localparam int FRAG_W = frag_width(X_BITS, Y_BITS, Z_BITS, COLOR_BITS),
    localparam int A_BITS = addr_width(X_BITS, Y_BITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FRAG_W-1:0]     frag_in,
    input  logic                  frag_ack,
    input  logic [FILL_BITS-1:0]  fifo_fill,
    output logic                  frag_req,
    input  logic                  clear_start,
    output logic                  fb_we,
    output logic [A_BITS-1:0]     fb_addr,
    output logic [COLOR_BITS-1:0] fb_color,
    output logic                  busy,
    output logic                  clear_done,
    output logic [15:0]           pass_count,
    output logic [15:0]           fail_count
);

    state_t              state, state_nx;
    logic [A_BITS-1:0]   sweep_addr;
    logic                pending;
    logic [FRAG_W-1:0]   frag_q;
    logic [X_BITS-1:0]   fx;
    logic [Y_BITS-1:0]   fy;
    logic [Z_BITS-1:0]   fz;
    logic [COLOR_BITS-1:0] fc;
    logic [A_BITS-1:0]   faddr;
    logic [Z_BITS-1:0]   stored_z;
    logic                pass;
    logic                sweep_last;
    logic                ram_we;
    logic [A_BITS-1:0]   ram_waddr;
    logic [Z_BITS-1:0]   ram_wdata;

    assign fx    = X_BITS'(frag_x(frag_bus_t'(frag_q), X_BITS, Y_BITS, Z_BITS, COLOR_BITS));
    assign fy    = Y_BITS'(frag_y(frag_bus_t'(frag_q), Y_BITS, Z_BITS, COLOR_BITS));
    assign fz    = Z_BITS'(frag_z(frag_bus_t'(frag_q), Z_BITS, COLOR_BITS));
    assign fc    = COLOR_BITS'(frag_color(frag_bus_t'(frag_q), COLOR_BITS));
    assign faddr = {fy, fx};
    assign pass  = fz < stored_z;
    assign sweep_last = (sweep_addr == '1);

    depth_ram #(.A_BITS(A_BITS), .Z_BITS(Z_BITS)) u_depth (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (faddr),
        .rdata (stored_z)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (clear_start || pending) state_nx = CLEAR;
                else if (fifo_fill != '0)   state_nx = REQ;
            end
            CLEAR:    if (sweep_last) state_nx = IDLE;
            REQ:      state_nx = WAIT_ACK;
            WAIT_ACK: if (frag_ack) state_nx = TEST;
            TEST:     state_nx = IDLE;
            default:  state_nx = CLEAR;
        endcase
    end

    always_comb begin
        frag_req   = 1'b0;
        fb_we      = 1'b0;
        fb_addr    = '0;
        fb_color   = '0;
        clear_done = 1'b0;
        // Strobes stay quiet while reset is held so the sweep is counted from its release.
        if (!reset) begin
            unique case (state)
                REQ: frag_req = 1'b1;
                CLEAR: begin
                    fb_we      = 1'b1;
                    fb_addr    = sweep_addr;
                    fb_color   = BG_COLOR;
                    clear_done = sweep_last;
                end
                TEST: begin
                    if (pass) begin
                        fb_we    = 1'b1;
                        fb_addr  = faddr;
                        fb_color = fc;
                    end
                end
                default: ;
            endcase
        end
        busy      = (state != IDLE);
        ram_we    = fb_we;
        ram_waddr = fb_addr;
        ram_wdata = (state == CLEAR) ? Z_FAR[Z_BITS-1:0] : fz;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_addr <= '0;
            pending    <= 1'b0;
            frag_q     <= '0;
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            if (state == CLEAR) sweep_addr <= sweep_addr + 1'b1;
            // Pending is consumed when a sweep starts, so a request mid-sweep earns another sweep.
            if (state == IDLE)     pending <= 1'b0;
            else if (clear_start)  pending <= 1'b1;
            if (state == WAIT_ACK && frag_ack) frag_q <= frag_in;
            if (state == TEST) begin
                if (pass) pass_count <= pass_count + 16'd1;
                else      fail_count <= fail_count + 16'd1;
            end
        end
    end

endmodule
